lsu_mem_stage: RTL

Memory-access stage: sits between the execute/memory pipeline register and `mem_wb`, turning the instruction's load/store request into a data-bus transaction. It generates byte enables and replicated store data, and stalls the pipeline while the bus is busy. It presents the raw 32-bit load word as `mem_rdata`, which `mem_wb` captures on the cycle the stall releases.

---
 rtl/lsu_mem_stage_if.sv | 29 ++
 rtl/lsu_mem_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage_if.sv
// Data-bus interface between the LSU memory stage (master) and the data
// memory / bus fabric (slave).
//   dmem_req/we/addr/be/wdata : request channel, master -> slave
//   dmem_gnt                  : request accepted this cycle, slave -> master
//   dmem_rvalid/rdata         : read response, slave -> master
interface lsu_mem_stage_if #(
  parameter int CPU_WIDTH = 32
);
  localparam int BE_W = CPU_WIDTH / 8;

  logic                 dmem_req;
  logic                 dmem_we;
  logic [CPU_WIDTH-1:0] dmem_addr;
  logic [BE_W-1:0]      dmem_be;
  logic [CPU_WIDTH-1:0] dmem_wdata;
  logic                 dmem_gnt;
  logic                 dmem_rvalid;
  logic [CPU_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-access stage of the pipeline. Turns the EX/MEM load/store request
// into a single data-bus transaction, stalling the front of the pipeline
// until the bus completes. The raw 32-bit load word is registered and handed
// to write-back unmodified (extension/lane select happens there).
//   clk, rst_n              : clock, async active-low reset
//   ex_mem_mem_ren/wen      : load / store in stage
//   ex_mem_alu_res          : effective byte address
//   ex_mem_reg2_rdata       : store source data
//   ex_mem_mem_access_type  : 00 byte, 01 half, 10 word, 11 reserved
//   dmem (master modport)   : data bus
//   mem_rdata               : registered raw load word
//   mem_stall               : hold upstream pipeline registers
//   misalign_err            : misaligned / reserved-size access, no bus traffic

// One byte lane: its byte enable and its slice of the replicated store data.
module lsu_mem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] addr_lo,
  input  logic [1:0] acc_type,
  input  logic [7:0] byte_src,   // d[7:0]
  input  logic [7:0] half_src,   // byte of d[15:0] that lands in this lane
  input  logic [7:0] word_src,   // d[8*LANE +: 8]
  output logic       be,
  output logic [7:0] wdata
);
  localparam logic [1:0] LIDX = 2'(LANE);

  always_comb begin
    be    = 1'b0;
    wdata = word_src;
    case (acc_type)
      2'b00: begin
        be    = (addr_lo == LIDX);
        wdata = byte_src;
      end
      2'b01: begin
        be    = (addr_lo[1] == LIDX[1]);
        wdata = half_src;
      end
      2'b10: be = 1'b1;
      default: be = 1'b0;  // reserved size never reaches the bus
    endcase
  end
endmodule

module lsu_mem_stage #(
  parameter int CPU_WIDTH             = 32,
  parameter int MEM_ACCESS_TYPE_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ex_mem_mem_ren,
  input  logic                             ex_mem_mem_wen,
  input  logic [CPU_WIDTH-1:0]             ex_mem_alu_res,
  input  logic [CPU_WIDTH-1:0]             ex_mem_reg2_rdata,
  input  logic [MEM_ACCESS_TYPE_WIDTH-1:0] ex_mem_mem_access_type,
  lsu_mem_stage_if.master                  dmem,
  output logic [CPU_WIDTH-1:0]             mem_rdata,
  output logic                             mem_stall,
  output logic                             misalign_err
);
  localparam int NUM_LANES = CPU_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e               state_q;
  logic [CPU_WIDTH-1:0] rdata_q;

  logic       mem_op;
  logic       aligned;
  logic [1:0] acc_type;
  logic [1:0] addr_lo;

  assign mem_op   = ex_mem_mem_ren | ex_mem_mem_wen;
  assign acc_type = ex_mem_mem_access_type[1:0];
  assign addr_lo  = ex_mem_alu_res[1:0];

  always_comb begin
    case (acc_type)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_lo[0];
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Request channel: the upstream stall keeps these inputs stable for the
  // whole transaction, so they can be driven straight from EX/MEM.
  logic [NUM_LANES-1:0]      be_lane;
  logic [NUM_LANES-1:0][7:0] wdata_lane;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_mem_lane #(.LANE(g)) u_lane (
      .addr_lo  (addr_lo),
      .acc_type (acc_type),
      .byte_src (ex_mem_reg2_rdata[7:0]),
      .half_src (ex_mem_reg2_rdata[8*(g%2) +: 8]),
      .word_src (ex_mem_reg2_rdata[8*g +: 8]),
      .be       (be_lane[g]),
      .wdata    (wdata_lane[g])
    );
  end

  assign dmem.dmem_req   = (state_q == S_REQ);
  assign dmem.dmem_we    = ex_mem_mem_wen;
  assign dmem.dmem_addr  = {ex_mem_alu_res[CPU_WIDTH-1:2], 2'b00};
  assign dmem.dmem_be    = be_lane;
  assign dmem.dmem_wdata = wdata_lane;

  // Gated by rst_n so the pipeline sees no stall/error while reset is
  // asserted, even if EX/MEM still holds a memory op.
  assign mem_stall    = rst_n & (((state_q == S_IDLE) & mem_op & aligned) |
                                 (state_q == S_REQ) | (state_q == S_WAIT));
  assign misalign_err = rst_n & (state_q == S_IDLE) & mem_op & ~aligned;
  assign mem_rdata    = rdata_q;

  // rvalid outside WAIT is ignored; reset abandons any outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (mem_op && aligned) state_q <= S_REQ;
        S_REQ:  if (dmem.dmem_gnt) state_q <= ex_mem_mem_wen ? S_DONE : S_WAIT;
        S_WAIT: if (dmem.dmem_rvalid) begin
          rdata_q <= dmem.dmem_rdata;
          state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
